i2c_cmd_sequencer: RTL and testbench

- Command sequencer that sits directly upstream of the I2C master's host req/done interface.
- Buffers single-byte read/write commands in a command FIFO and issues them to the master one at a time.
- Collects each completion (read data and NACK status) into a response FIFO for the host.
- Hides the master's req/done timing rules from software-facing logic.

---
 rtl/i2c_cmd_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Command/response sequencer in front of an I2C master's req/done host port.
// Optional command timeout with a HALT state: define I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_rw_i,
  input  logic [6:0]                 cmd_addr_i,
  input  logic [7:0]                 cmd_data_i,
  input  logic                       flush_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic                       rsp_rw_o,
  output logic [7:0]                 rsp_data_o,
  output logic                       rsp_nack_o,
  output logic                       rsp_timeout_o,
  output logic                       busy_o,
  output logic [$clog2(CMD_DEPTH):0] cmd_count_o,
  output logic                       m_req_o,
  output logic                       m_rw_o,
  output logic [6:0]                 m_addr_o,
  output logic [7:0]                 m_data_o,
  input  logic [7:0]                 m_data_i,
  input  logic                       m_done_i,
  input  logic                       m_ack_error_i
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0] RSP_FULL = (RAW+1)'(RSP_DEPTH);
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int RSP_W = 11;
`else
  localparam int RSP_W = 10;
`endif

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
    $error("CMD_DEPTH must be a power of 2 and at least 2");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
    $error("RSP_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_HALT} state_e;

  state_e           state_q, state_d;
  logic             m_req_q, m_req_d;
  logic             m_rw_q;
  logic [6:0]       m_addr_q;
  logic [7:0]       m_data_q;

  logic [15:0]      cmd_mem_q [CMD_DEPTH];
  logic [CAW-1:0]   cmd_wr_q, cmd_rd_q;
  logic [CAW:0]     cmd_cnt_q;
  logic             cmd_avail_q;
  logic             cmd_push, cmd_pop, cmd_full;

  logic [RSP_W-1:0] rsp_mem_q [RSP_DEPTH];
  logic [RAW-1:0]   rsp_wr_q, rsp_rd_q;
  logic [RAW:0]     rsp_cnt_q;
  logic             rsp_push, rsp_pop, rsp_full;
  logic [RSP_W-1:0] rsp_wdata;

  logic             issue_ok, tmo_hit;

  // Command FIFO: a freshly written entry becomes eligible one cycle after it lands
  assign cmd_full    = (cmd_cnt_q == CMD_FULL);
  assign cmd_ready_o = !cmd_full && !flush_i;
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign cmd_count_o = cmd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      cmd_avail_q <= 1'b0;
    end else begin
      if (cmd_push) cmd_wr_q <= cmd_wr_q + CAW'(1);
      if (cmd_pop)  cmd_rd_q <= cmd_rd_q + CAW'(1);
      cmd_cnt_q   <= cmd_cnt_q + {{CAW{1'b0}}, cmd_push} - {{CAW{1'b0}}, cmd_pop};
      cmd_avail_q <= (cmd_cnt_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= {cmd_rw_i, cmd_addr_i, cmd_data_i};
  end

  // Response FIFO, first-word fall-through; outputs forced to zero while empty
  assign rsp_full    = (rsp_cnt_q == RSP_FULL);
  assign rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (rsp_push) rsp_wr_q <= rsp_wr_q + RAW'(1);
      if (rsp_pop)  rsp_rd_q <= rsp_rd_q + RAW'(1);
      rsp_cnt_q <= rsp_cnt_q + {{RAW{1'b0}}, rsp_push} - {{RAW{1'b0}}, rsp_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem_q[rsp_wr_q] <= rsp_wdata;
  end

  assign rsp_rw_o   = rsp_valid_o & rsp_mem_q[rsp_rd_q][RSP_W-1];
  assign rsp_data_o = rsp_valid_o ? rsp_mem_q[rsp_rd_q][RSP_W-2 -: 8] : 8'h00;
  assign rsp_nack_o = rsp_valid_o & rsp_mem_q[rsp_rd_q][RSP_W-10];
`ifdef I2C_SEQ_TIMEOUT_EN
  assign rsp_timeout_o = rsp_valid_o & rsp_mem_q[rsp_rd_q][0];
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Timeout counter runs only while a request is outstanding
`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_ISSUE) tmo_cnt_q <= '0;
    else                           tmo_cnt_q <= tmo_cnt_q + 32'd1;
  end

  assign tmo_hit = (state_q == S_ISSUE) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Reserving a response slot at issue time means a completion can never be dropped
  assign issue_ok = cmd_avail_q && (cmd_cnt_q != '0) && !rsp_full && !m_done_i && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (issue_ok) state_d = S_ISSUE;
      S_ISSUE: begin
        if (m_done_i)     state_d = S_RELEASE;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_RELEASE: if (!m_done_i) state_d = S_IDLE;
`ifdef I2C_SEQ_TIMEOUT_EN
      S_HALT:    if (flush_i) state_d = S_RELEASE;
`else
      S_HALT:    state_d = S_IDLE;
`endif
    endcase
  end

  always_comb begin
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    rsp_wdata = '0;
    m_req_d   = m_req_q;
    busy_o    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (issue_ok) begin
          cmd_pop = 1'b1;
          m_req_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (m_done_i) begin
          m_req_d  = 1'b0;
          rsp_push = 1'b1;
          rsp_wdata[RSP_W-1 -: 10] = {m_rw_q, (m_rw_q ? m_data_i : 8'h00), m_ack_error_i};
        end else if (tmo_hit) begin
          m_req_d   = 1'b0;
          rsp_push  = 1'b1;
          rsp_wdata = '1;
          rsp_wdata[RSP_W-1 -: 9] = {m_rw_q, 8'h00};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_req_q  <= 1'b0;
      m_rw_q   <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
    end else begin
      m_req_q <= m_req_d;
      if (cmd_pop) {m_rw_q, m_addr_q, m_data_q} <= cmd_mem_q[cmd_rd_q];
    end
  end

  assign m_req_o  = m_req_q;
  assign m_rw_o   = m_rw_q;
  assign m_addr_o = m_addr_q;
  assign m_data_o = m_data_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural req/done master model.
module tb_i2c_cmd_sequencer;

  logic       clk, rst;
  logic       cmd_valid_i, cmd_ready_o, cmd_rw_i, flush_i;
  logic [6:0] cmd_addr_i;
  logic [7:0] cmd_data_i;
  logic       rsp_valid_o, rsp_ready_i, rsp_rw_o, rsp_nack_o, rsp_timeout_o, busy_o;
  logic [7:0] rsp_data_o;
  logic [2:0] cmd_count_o;
  logic       m_req_o, m_rw_o, m_done_i, m_ack_error_i;
  logic [6:0] m_addr_o;
  logic [7:0] m_data_o, m_data_i;

  i2c_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rw_i(cmd_rw_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rw_o(rsp_rw_o),
    .rsp_data_o(rsp_data_o), .rsp_nack_o(rsp_nack_o), .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o), .cmd_count_o(cmd_count_o),
    .m_req_o(m_req_o), .m_rw_o(m_rw_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_data_i(m_data_i), .m_done_i(m_done_i), .m_ack_error_i(m_ack_error_i)
  );

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
    logic       ack;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_nack;
  } vec_t;

  vec_t        vecs [6];
  int          n_vec = 0;
  int          n_miss = 0;
  int          mdl_delay = 40;
  int          mdl_hold = 1;
  logic        mdl_stall = 1'b0;
  logic        mdl_echo = 1'b0;
  logic [7:0]  mdl_rdata = 8'h00;
  logic [15:0] issued [$];
  logic        mon_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Master model: done after mdl_delay cycles of req, held for mdl_hold cycles
  initial begin
    int wcnt;
    int hcnt;
    wcnt = 0;
    hcnt = 0;
    m_done_i = 1'b0;
    m_data_i = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        m_done_i = 1'b0;
        wcnt = 0;
      end else if (m_done_i) begin
        if (hcnt > 1) hcnt--;
        else m_done_i = 1'b0;
      end else if (m_req_o && !mdl_stall) begin
        if (wcnt >= mdl_delay - 1) begin
          m_data_i = mdl_echo ? {1'b1, m_addr_o} : mdl_rdata;
          m_done_i = 1'b1;
          hcnt = mdl_hold;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Log of commands as presented at each rising edge of m_req_o
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(posedge clk); #3;
      if (rst) mon_prev = 1'b0;
      else begin
        if (m_req_o && !mon_prev) issued.push_back({m_rw_o, m_addr_o, m_data_o});
        mon_prev = m_req_o;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d, output bit ok);
    int t;
    t = 0;
    cmd_valid_i = 1'b1;
    cmd_rw_i    = rw;
    cmd_addr_i  = a;
    cmd_data_i  = d;
    while (!cmd_ready_o && t < 500) begin
      step();
      t++;
    end
    ok = cmd_ready_o;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic pop_rsp();
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int t);
    t = 0;
    while (!rsp_valid_o && t < limit) begin
      step();
      t++;
    end
  endtask

  task automatic wait_req(input int limit, output int t);
    t = 0;
    while (!m_req_o && t < limit) begin
      step();
      t++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    int t;
    issued.delete();
    mdl_rdata = v.rdata;
    m_ack_error_i = v.ack;
    mdl_hold = v.hold;
    mdl_delay = 40;
    push_cmd(v.rw, v.addr, v.data, ok);
    chk($sformatf("v%0d_push_ok", idx), 32'(ok), 32'd1);
    wait_req(10, t);
    chk($sformatf("v%0d_req_latency", idx), t, 32'd2);
    chk($sformatf("v%0d_m_rw", idx), 32'(m_rw_o), 32'(v.rw));
    chk($sformatf("v%0d_m_addr", idx), 32'(m_addr_o), 32'(v.addr));
    chk($sformatf("v%0d_m_data", idx), 32'(m_data_o), 32'(v.data));
    wait_rsp(100, t);
    chk($sformatf("v%0d_rsp_latency", idx), t, 32'd40);
    chk($sformatf("v%0d_req_drop", idx), 32'(m_req_o), 32'd0);
    chk($sformatf("v%0d_rsp_rw", idx), 32'(rsp_rw_o), 32'(v.rw));
    chk($sformatf("v%0d_rsp_data", idx), 32'(rsp_data_o), 32'(v.exp_data));
    chk($sformatf("v%0d_rsp_nack", idx), 32'(rsp_nack_o), 32'(v.exp_nack));
    chk($sformatf("v%0d_rsp_timeout", idx), 32'(rsp_timeout_o), 32'd0);
    pop_rsp();
    chk($sformatf("v%0d_single_rsp", idx), 32'(rsp_valid_o), 32'd0);
    repeat (v.hold + 3) step();
    chk($sformatf("v%0d_idle_after", idx), 32'(busy_o), 32'd0);
    chk($sformatf("v%0d_one_req", idx), issued.size(), 32'd1);
  endtask

  initial begin
    bit ok;
    int t;
    int got;

    vecs[0] = '{1'b0, 7'h50, 8'hA5, 8'hFF, 1'b0, 1,  8'h00, 1'b0};
    vecs[1] = '{1'b1, 7'h21, 8'h00, 8'h3C, 1'b0, 10, 8'h3C, 1'b0};
    vecs[2] = '{1'b0, 7'h7F, 8'h00, 8'h77, 1'b0, 1,  8'h00, 1'b0};
    vecs[3] = '{1'b1, 7'h00, 8'h5A, 8'hFF, 1'b0, 1,  8'hFF, 1'b0};
    vecs[4] = '{1'b1, 7'h55, 8'h00, 8'h81, 1'b1, 1,  8'h81, 1'b1};
    vecs[5] = '{1'b0, 7'h12, 8'h5A, 8'h99, 1'b1, 1,  8'h00, 1'b1};

    rst = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_rw_i = 1'b0;
    cmd_addr_i = '0;
    cmd_data_i = '0;
    flush_i = 1'b0;
    rsp_ready_i = 1'b0;
    m_ack_error_i = 1'b0;
    do_reset();

    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count_o), 32'd0);
    chk("rst_m_req", 32'(m_req_o), 32'd0);
    chk("rst_m_fields", {16'h0, m_rw_o, m_addr_o, m_data_o}, 32'd0);
    chk("rst_rsp_fields", {21'h0, rsp_rw_o, rsp_data_o, rsp_nack_o, rsp_timeout_o}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    m_ack_error_i = 1'b0;

    // Done held 10 cycles: the queued second read must wait for done to fall
    mdl_hold = 10;
    mdl_echo = 1'b1;
    mdl_delay = 40;
    push_cmd(1'b1, 7'h21, 8'h00, ok);
    push_cmd(1'b1, 7'h22, 8'h00, ok);
    wait_rsp(200, t);
    chk("hold_rsp1_data", 32'(rsp_data_o), 32'hA1);
    wait_req(50, t);
    chk("hold_req_gap", t, 32'd11);
    chk("hold_req2_addr", 32'(m_addr_o), 32'h22);
    pop_rsp();
    wait_rsp(200, t);
    chk("hold_rsp2_data", 32'(rsp_data_o), 32'hA2);
    pop_rsp();
    t = 0;
    while (busy_o && t < 50) begin step(); t++; end
    mdl_hold = 1;

    // Command FIFO full with the master stalled
    issued.delete();
    mdl_stall = 1'b1;
    mdl_delay = 5;
    for (int k = 0; k < 5; k++) begin
      push_cmd(1'b1, 7'(1 + k), 8'(8'h10 + k), ok);
      chk($sformatf("full_push%0d_ok", k), 32'(ok), 32'd1);
    end
    chk("full_count", 32'(cmd_count_o), 32'd4);
    chk("full_ready", 32'(cmd_ready_o), 32'd0);
    chk("full_req", 32'(m_req_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_rw_i = 1'b1;
    cmd_addr_i = 7'h7E;
    repeat (3) step();
    cmd_valid_i = 1'b0;
    chk("full_reject_count", 32'(cmd_count_o), 32'd4);
    mdl_stall = 1'b0;
    rsp_ready_i = 1'b1;
    got = 0;
    t = 0;
    while (got < 5 && t < 400) begin
      if (rsp_valid_o) begin
        chk($sformatf("full_rsp%0d_data", got), 32'(rsp_data_o), 32'(8'h81 + got));
        got++;
      end
      step();
      t++;
    end
    rsp_ready_i = 1'b0;
    chk("full_rsp_total", got, 32'd5);
    repeat (10) step();
    chk("full_issue_total", issued.size(), 32'd5);
    for (int k = 0; k < 5 && k < issued.size(); k++)
      chk($sformatf("full_issue%0d", k), 32'(issued[k]), {16'h0, 1'b1, 7'(1 + k), 8'(8'h10 + k)});

    // Response FIFO full: issuing stops at four and resumes one per pop
    issued.delete();
    mdl_delay = 3;
    for (int k = 0; k < 6; k++) begin
      push_cmd(1'b1, 7'(7'h30 + k), 8'h00, ok);
      chk($sformatf("rfull_push%0d_ok", k), 32'(ok), 32'd1);
    end
    repeat (60) step();
    chk("rfull_issued4", issued.size(), 32'd4);
    chk("rfull_cmd_count", 32'(cmd_count_o), 32'd2);
    chk("rfull_busy", 32'(busy_o), 32'd0);
    chk("rfull_rsp0_data", 32'(rsp_data_o), 32'hB0);
    pop_rsp();
    repeat (30) step();
    chk("rfull_issued5", issued.size(), 32'd5);
    chk("rfull_cmd_count1", 32'(cmd_count_o), 32'd1);
    chk("rfull_rsp1_data", 32'(rsp_data_o), 32'hB1);
    pop_rsp();
    repeat (30) step();
    chk("rfull_issued6", issued.size(), 32'd6);
    for (int k = 2; k < 6; k++) begin
      chk($sformatf("rfull_rsp%0d_valid", k), 32'(rsp_valid_o), 32'd1);
      chk($sformatf("rfull_rsp%0d_data", k), 32'(rsp_data_o), 32'(8'hB0 + k));
      pop_rsp();
    end
    chk("rfull_drained", 32'(rsp_valid_o), 32'd0);

    // Flush with one command in flight and three queued
    issued.delete();
    mdl_stall = 1'b1;
    mdl_delay = 5;
    for (int k = 0; k < 4; k++) push_cmd(1'b0, 7'(7'h40 + k), 8'(8'hC0 + k), ok);
    chk("flush_pre_count", 32'(cmd_count_o), 32'd3);
    chk("flush_pre_addr", 32'(m_addr_o), 32'h40);
    flush_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_addr_i = 7'h4F;
    #1;
    chk("flush_ready_low", 32'(cmd_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    cmd_valid_i = 1'b0;
    chk("flush_count", 32'(cmd_count_o), 32'd0);
    chk("flush_inflight_req", 32'(m_req_o), 32'd1);
    mdl_stall = 1'b0;
    wait_rsp(100, t);
    chk("flush_rsp_seen", 32'(rsp_valid_o), 32'd1);
    chk("flush_rsp_fields", {21'h0, rsp_rw_o, rsp_data_o, rsp_nack_o, rsp_timeout_o}, 32'd0);
    pop_rsp();
    repeat (40) step();
    chk("flush_no_more_req", issued.size(), 32'd1);
    chk("flush_no_more_rsp", 32'(rsp_valid_o), 32'd0);
    chk("flush_idle", 32'(busy_o), 32'd0);

    // Reset in the middle of a transaction
    issued.delete();
    mdl_stall = 1'b1;
    push_cmd(1'b0, 7'h11, 8'h22, ok);
    push_cmd(1'b0, 7'h13, 8'h44, ok);
    wait_req(10, t);
    chk("mrst_req_before", 32'(m_req_o), 32'd1);
    rst = 1'b1;
    step();
    chk("mrst_req", 32'(m_req_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_count", 32'(cmd_count_o), 32'd0);
    chk("mrst_ready", 32'(cmd_ready_o), 32'd1);
    chk("mrst_m_fields", {16'h0, m_rw_o, m_addr_o, m_data_o}, 32'd0);
    rst = 1'b0;
    mdl_stall = 1'b0;
    repeat (20) step();
    chk("mrst_quiet", 32'(m_req_o | rsp_valid_o | busy_o), 32'd0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master never answers: timeout response, HALT until flush
    issued.delete();
    mdl_stall = 1'b1;
    push_cmd(1'b1, 7'h33, 8'h00, ok);
    wait_req(10, t);
    wait_rsp(300, t);
    chk("tmo_latency", t, 32'd100);
    chk("tmo_rsp_fields", {21'h0, rsp_rw_o, rsp_data_o, rsp_nack_o, rsp_timeout_o}, 32'h403);
    chk("tmo_req_low", 32'(m_req_o), 32'd0);
    pop_rsp();
    push_cmd(1'b0, 7'h34, 8'h01, ok);
    repeat (20) step();
    chk("tmo_halt_busy", 32'(busy_o), 32'd1);
    chk("tmo_halt_no_issue", issued.size(), 32'd1);
    chk("tmo_halt_count", 32'(cmd_count_o), 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("tmo_release_busy", 32'(busy_o), 32'd1);
    chk("tmo_flush_count", 32'(cmd_count_o), 32'd0);
    step();
    chk("tmo_idle", 32'(busy_o), 32'd0);
    mdl_stall = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
